hamming_apb_sequencer: RTL and testbench
========================================

# hamming_apb_sequencer

Fabric-side APB master that runs one full Hamming round trip per request. It writes a data word to the encoder slave and reads back the codeword. It then XORs a caller-supplied error mask into that codeword, writes the result to the decoder slave, and reads back the corrected data and the error flag. It sits between a fabric requester (self-test or scrub logic) and the encoder/decoder APB slaves, and owns their PSEL/PENABLE sequencing.

## Interface
- DATA_W, 4: payload width; PWDATA[DATA_W-1:0] on encoder write, PRDATA[DATA_W-1:0] on decoder read.
- CW_W, 7: codeword width; encoder PRDATA[CW_W-1:0], decoder PWDATA[CW_W-1:0].
- TIMEOUT, 16: max access-phase cycles waiting for PREADY (2..255).
- PCLK  in  1  sole clock; all state updates on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1  request handshake; transfer on PCLK edge with both high.
- req_data  in  DATA_W  payload to encode.
- req_errmask  in  CW_W  bits flipped in the codeword before decoding.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_data  out  DATA_W  decoder output data.
- rsp_codeword  out  CW_W  encoder output (before masking).
- rsp_corrected  out  1  decoder PRDATA[16] (error detected/corrected).
- rsp_mismatch  out  1  rsp_data != latched req_data.
- rsp_status  out  2  00 ok, 01 PSLVERR, 10 timeout.
- PADDR  out  32  always 32'h0 (data register of both slaves).
- PSEL_ENC, PSEL_DEC, PENABLE, PWRITE  out  1  APB controls.
- PWDATA  out  32  write data, zero-extended.
- PRDATA_ENC, PRDATA_DEC  in  32; PREADY_ENC, PREADY_DEC, PSLVERR_ENC, PSLVERR_DEC  in  1.

## Operation
- States: IDLE, ENC_WR, ENC_RD, DEC_WR, DEC_RD, RESP. Each transfer state has a SETUP and an ACCESS sub-phase.
- IDLE: req_ready=1. On handshake, latch req_data and req_errmask, go to ENC_WR.SETUP.
- SETUP: assert the target PSEL, set PWRITE/PWDATA, PENABLE=0. Always lasts 1 cycle.
- ACCESS: PENABLE=1 with PSEL and all signals held stable. Stay until the selected PREADY=1.
- On a completing cycle of a read, capture PRDATA: encoder read into the codeword register; decoder read into data and the flag.
- DEC_WR writes the codeword XOR mask.
- A completing cycle with the selected PSLVERR=1 sets status 01 and goes straight to RESP; remaining transfers are skipped.
- Timeout: a wait counter clears in SETUP and increments each ACCESS cycle with PREADY=0. If it reaches TIMEOUT, set status 10, drop PSEL/PENABLE and go to RESP.
- On an aborted transaction, rsp_data, rsp_codeword and rsp_corrected hold their last captured values; rsp_mismatch is forced to 0.
- RESP: rsp_valid=1, outputs stable. On rsp_ready, return to IDLE.
- At most one PSEL is high at any time; both are low outside SETUP/ACCESS.
- Reset, at any point including mid-transfer, forces: state IDLE, all P* outputs 0, rsp_valid 0, req_ready 1, all rsp_* 0.

## Timing
- Zero-wait slaves: accept edge t0 → ENC_WR SETUP/ACCESS t1/t2, ENC_RD t3/t4, DEC_WR t5/t6, DEC_RD t7/t8. rsp_valid rises on the cycle after t8 (9 cycles from accept).
- Each wait state adds exactly 1 cycle.
- req_ready is 0 from the accept edge until the cycle after the rsp handshake. A new request can be accepted 1 cycle after the response handshake (no back-to-back overlap).
- rsp_ready held high before rsp_valid: the response is consumed in its first cycle.
- All outputs are registered; no combinational path from PREADY/PRDATA to outputs.

## Structure
- Package hamming_seq_pkg holds:
  - state enum;
  - status codes (ST_OK, ST_SLVERR, ST_TIMEOUT);
  - register offset 32'h0;
  - flag bit index 16.
- One sub-module, hamming_apb_xfer: single-transfer SETUP/ACCESS engine with the timeout counter. The sequencer instantiates it once and muxes slave inputs on a target select.

## Test plan
- req_data=4'hB, mask=0, zero-wait slave model → encoder sees write 0xB; decoder receives the unmasked codeword; response 9 cycles after accept; rsp_data=0xB, corrected=0, mismatch=0, status 00.
- req_data=4'h5, mask=7'h04 → decoder PWDATA = codeword^0x04; rsp_corrected=1, rsp_data=0x5.
- Encoder PREADY low for 3 cycles on the read → latency 12; PADDR/PWRITE/PSEL stable throughout ACCESS.
- Decoder PSLVERR=1 on DEC_WR → status 01; no DEC_RD transfer occurs; mismatch=0.
- Decoder PREADY stuck low, TIMEOUT=16 → PSEL_DEC drops after 16 access cycles; status 10.
- PRESET pulsed during ENC_RD ACCESS → all P* outputs 0 asynchronously; req_ready=1 after release; the next request completes normally.

Source files
------------

// File: rtl/hamming_apb_sequencer_pkg.sv
// Shared types and constants for the Hamming round-trip APB sequencer.
package hamming_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENC_WR,
        ENC_RD,
        DEC_WR,
        DEC_RD,
        RESP
    } seq_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SLVERR  = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_t;

    localparam logic [31:0] REG_OFF  = 32'h0;
    localparam int          FLAG_BIT = 16;

endpackage

// File: rtl/hamming_apb_sequencer_if.sv
// Fabric request/response channel and the dual-slave APB bus of the sequencer.
interface hseq_req_if
    import hamming_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CW_W   = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [CW_W-1:0]   req_errmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [CW_W-1:0]   rsp_codeword;
    logic              rsp_corrected;
    logic              rsp_mismatch;
    status_t           rsp_status;

    modport master (
        output req_valid, req_data, req_errmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_codeword, rsp_corrected,
               rsp_mismatch, rsp_status
    );

    modport slave (
        input  req_valid, req_data, req_errmask, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_codeword, rsp_corrected,
               rsp_mismatch, rsp_status
    );
endinterface

interface hseq_apb_if;
    logic [31:0] PADDR;
    logic        PSEL_ENC;
    logic        PSEL_DEC;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA_ENC;
    logic [31:0] PRDATA_DEC;
    logic        PREADY_ENC;
    logic        PREADY_DEC;
    logic        PSLVERR_ENC;
    logic        PSLVERR_DEC;

    modport master (
        output PADDR, PSEL_ENC, PSEL_DEC, PENABLE, PWRITE, PWDATA,
        input  PRDATA_ENC, PRDATA_DEC, PREADY_ENC, PREADY_DEC, PSLVERR_ENC, PSLVERR_DEC
    );

    modport slave (
        input  PADDR, PSEL_ENC, PSEL_DEC, PENABLE, PWRITE, PWDATA,
        output PRDATA_ENC, PRDATA_DEC, PREADY_ENC, PREADY_DEC, PSLVERR_ENC, PSLVERR_DEC
    );
endinterface

// File: rtl/hamming_apb_sequencer_xfer.sv
// One APB transfer: a single SETUP cycle, then ACCESS until PREADY or the wait limit.
module hamming_apb_xfer
    import hamming_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        tgt_dec_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic        pready_i,
    output logic        psel_enc_o,
    output logic        psel_dec_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic        done_o,
    output logic        timeout_o
);
    logic        psel_enc_q, psel_dec_q, penable_q, pwrite_q;
    logic [31:0] pwdata_q;
    logic [7:0]  wait_q;
    logic        setup;

    assign setup     = (psel_enc_q | psel_dec_q) & ~penable_q;
    assign done_o    = penable_q & pready_i;
    assign timeout_o = penable_q & ~pready_i & (wait_q == 8'(TIMEOUT - 1));

    // start_i may coincide with done_o so back-to-back transfers need no idle gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_enc_q <= 1'b0;
            psel_dec_q <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            wait_q     <= '0;
        end else if (start_i) begin
            psel_enc_q <= ~tgt_dec_i;
            psel_dec_q <= tgt_dec_i;
            penable_q  <= 1'b0;
            pwrite_q   <= write_i;
            pwdata_q   <= wdata_i;
        end else if (setup) begin
            penable_q <= 1'b1;
            wait_q    <= '0;
        end else if (penable_q) begin
            if (pready_i || timeout_o) begin
                psel_enc_q <= 1'b0;
                psel_dec_q <= 1'b0;
                penable_q  <= 1'b0;
            end else begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    assign psel_enc_o = psel_enc_q;
    assign psel_dec_o = psel_dec_q;
    assign penable_o  = penable_q;
    assign pwrite_o   = pwrite_q;
    assign pwdata_o   = pwdata_q;

endmodule

// File: rtl/hamming_apb_sequencer.sv
// Runs encode-write, encode-read, masked decode-write, decode-read per fabric request.
module hamming_apb_sequencer
    import hamming_seq_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CW_W    = 7,
    parameter int TIMEOUT = 16
) (
    input logic        PCLK,
    input logic        PRESET,
    hseq_req_if.slave  rq,
    hseq_apb_if.master apb
);
    seq_state_t        state_q;
    logic [DATA_W-1:0] data_q, rdata_q;
    logic [CW_W-1:0]   mask_q, cw_q;
    logic              corr_q, mism_q, req_ready_q, rsp_valid_q;
    status_t           status_q;

    logic        accept, start, tgt_dec, wr;
    logic [31:0] wdata;
    logic        psel_enc, psel_dec, done, tmo, pready, pslverr, err;
    logic        unused_prdata;

    assign accept  = rq.req_valid & req_ready_q;
    assign pready  = psel_dec ? apb.PREADY_DEC  : apb.PREADY_ENC;
    assign pslverr = psel_dec ? apb.PSLVERR_DEC : apb.PSLVERR_ENC;
    assign err     = done & pslverr;
    assign unused_prdata = ^{apb.PRDATA_ENC[31:CW_W], apb.PRDATA_DEC[31:FLAG_BIT+1],
                             apb.PRDATA_DEC[FLAG_BIT-1:DATA_W]};

    // Next transfer is launched on the completing edge of the previous one
    always_comb begin
        start   = 1'b0;
        tgt_dec = 1'b0;
        wr      = 1'b0;
        wdata   = '0;
        unique case (state_q)
            IDLE: begin
                start = accept;
                wr    = 1'b1;
                wdata = 32'(rq.req_data);
            end
            ENC_WR: start = done & ~err;
            ENC_RD: begin
                start   = done & ~err;
                tgt_dec = 1'b1;
                wr      = 1'b1;
                wdata   = 32'(apb.PRDATA_ENC[CW_W-1:0] ^ mask_q);
            end
            DEC_WR: begin
                start   = done & ~err;
                tgt_dec = 1'b1;
            end
            default: ;
        endcase
    end

    hamming_apb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .clk       (PCLK),
        .rst       (PRESET),
        .start_i   (start),
        .tgt_dec_i (tgt_dec),
        .write_i   (wr),
        .wdata_i   (wdata),
        .pready_i  (pready),
        .psel_enc_o(psel_enc),
        .psel_dec_o(psel_dec),
        .penable_o (apb.PENABLE),
        .pwrite_o  (apb.PWRITE),
        .pwdata_o  (apb.PWDATA),
        .done_o    (done),
        .timeout_o (tmo)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
            mask_q      <= '0;
            cw_q        <= '0;
            rdata_q     <= '0;
            corr_q      <= 1'b0;
            mism_q      <= 1'b0;
            status_q    <= ST_OK;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    data_q      <= rq.req_data;
                    mask_q      <= rq.req_errmask;
                    req_ready_q <= 1'b0;
                    state_q     <= ENC_WR;
                end
                RESP: if (rq.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    // Aborts keep previously captured data/codeword/flag
                    if (err || tmo) begin
                        status_q    <= err ? ST_SLVERR : ST_TIMEOUT;
                        mism_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (done) begin
                        case (state_q)
                            ENC_WR: state_q <= ENC_RD;
                            ENC_RD: begin
                                cw_q    <= apb.PRDATA_ENC[CW_W-1:0];
                                state_q <= DEC_WR;
                            end
                            DEC_WR: state_q <= DEC_RD;
                            default: begin
                                rdata_q     <= apb.PRDATA_DEC[DATA_W-1:0];
                                corr_q      <= apb.PRDATA_DEC[FLAG_BIT];
                                mism_q      <= apb.PRDATA_DEC[DATA_W-1:0] != data_q;
                                status_q    <= ST_OK;
                                rsp_valid_q <= 1'b1;
                                state_q     <= RESP;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign apb.PADDR        = REG_OFF;
    assign apb.PSEL_ENC     = psel_enc;
    assign apb.PSEL_DEC     = psel_dec;
    assign rq.req_ready     = req_ready_q;
    assign rq.rsp_valid     = rsp_valid_q;
    assign rq.rsp_data      = rdata_q;
    assign rq.rsp_codeword  = cw_q;
    assign rq.rsp_corrected = corr_q;
    assign rq.rsp_mismatch  = mism_q;
    assign rq.rsp_status    = status_q;

endmodule

// File: tb/tb_hamming_apb_sequencer.sv
// Scoreboard bench: behavioural Hamming(7,4) slaves, queued expectations, decoupled monitor.
module tb_hamming_apb_sequencer;
    localparam int TMO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    hseq_req_if #(.DATA_W(4), .CW_W(7)) rq ();
    hseq_apb_if ab ();

    hamming_apb_sequencer #(.DATA_W(4), .CW_W(7), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .rq(rq), .apb(ab)
    );

    typedef struct {
        logic [3:0]  data;
        logic [6:0]  cw;
        logic        corr;
        logic        mism;
        logic [1:0]  st;
        logic [31:0] enc_w;
        logic [31:0] dec_w;
        int          rds;
        int          lat;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int cfg_w[4];
    int cfg_mode;
    bit rr_rand = 0;
    int dec_rds;
    logic [31:0] enc_w_seen, dec_w_seen;
    logic [3:0] prev_data;
    logic [6:0] prev_cw;
    logic       prev_corr;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [6:0] ham_enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    endfunction

    // returns {error_flag, corrected data}
    function automatic logic [4:0] ham_dec(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] x;
        s[0] = c[0]^c[2]^c[4]^c[6];
        s[1] = c[1]^c[2]^c[5]^c[6];
        s[2] = c[3]^c[4]^c[5]^c[6];
        x = c;
        if (s != 3'd0) x[s-3'd1] = ~x[s-3'd1];
        return {s != 3'd0, x[6], x[5], x[4], x[2]};
    endfunction

    // Encoder/decoder slaves with configurable wait states, error and stuck-PREADY modes
    initial begin
        logic [3:0] enc_mem;
        logic [6:0] dec_mem;
        logic [31:0] r;
        logic [33:0] held;
        logic [4:0] dv;
        int k, w;
        bit stuck, rdy;
        enc_mem = '0; dec_mem = '0; k = 0; held = '0;
        ab.PREADY_ENC = 0; ab.PREADY_DEC = 0; ab.PSLVERR_ENC = 0; ab.PSLVERR_DEC = 0;
        ab.PRDATA_ENC = '0; ab.PRDATA_DEC = '0;
        forever begin
            @(posedge PCLK); #1;
            ab.PREADY_ENC = 0; ab.PREADY_DEC = 0; ab.PSLVERR_ENC = 0; ab.PSLVERR_DEC = 0;
            check("psel_onehot", ab.PSEL_ENC & ab.PSEL_DEC, 0);
            if (ab.PSEL_ENC || ab.PSEL_DEC) begin
                if (!ab.PENABLE) begin
                    k = 0;
                    held = {ab.PSEL_ENC, ab.PWRITE, ab.PWDATA};
                    check("paddr", ab.PADDR, 0);
                    if (ab.PWRITE && ab.PSEL_ENC) enc_w_seen = ab.PWDATA;
                    if (ab.PWRITE && ab.PSEL_DEC) dec_w_seen = ab.PWDATA;
                end else begin
                    check("access_hold", {ab.PSEL_ENC, ab.PWRITE, ab.PWDATA, ab.PADDR}, {held, 32'h0});
                    w = ab.PSEL_ENC ? (ab.PWRITE ? cfg_w[0] : cfg_w[1]) : (ab.PWRITE ? cfg_w[2] : cfg_w[3]);
                    stuck = ab.PSEL_DEC && ab.PWRITE && cfg_mode == 2;
                    rdy = !stuck && k >= w;
                    k++;
                    r = $urandom;
                    if (ab.PSEL_ENC) begin
                        ab.PREADY_ENC = rdy;
                        if (rdy && ab.PWRITE) enc_mem = ab.PWDATA[3:0];
                        if (rdy && !ab.PWRITE) begin r[6:0] = ham_enc(enc_mem); ab.PRDATA_ENC = r; end
                    end else begin
                        ab.PREADY_DEC = rdy;
                        if (rdy && ab.PWRITE) begin dec_mem = ab.PWDATA[6:0]; ab.PSLVERR_DEC = (cfg_mode == 1); end
                        if (rdy && !ab.PWRITE) begin
                            dv = ham_dec(dec_mem);
                            r[16] = dv[4]; r[3:0] = dv[3:0];
                            ab.PRDATA_DEC = r;
                            dec_rds++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rq.rsp_ready = 1'b1;
        forever begin
            @(posedge PCLK); #1;
            rq.rsp_ready = rr_rand ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Monitor: compares whenever a response is presented and taken
    initial begin
        exp_t e;
        forever begin
            @(posedge PCLK); #2;
            if (!PRESET && rq.rsp_valid && rq.rsp_ready) begin
                if (sb.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_status", rq.rsp_status, e.st);
                    check("rsp_data", rq.rsp_data, e.data);
                    check("rsp_codeword", rq.rsp_codeword, e.cw);
                    check("rsp_corrected", rq.rsp_corrected, e.corr);
                    check("rsp_mismatch", rq.rsp_mismatch, e.mism);
                    check("enc_pwdata", enc_w_seen, e.enc_w);
                    check("dec_pwdata", dec_w_seen, e.dec_w);
                    check("dec_reads", dec_rds, e.rds);
                    if (e.chk_lat) check("latency", cyc + 1 - acc_cyc, e.lat);
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [6:0] m, output bit ok);
        int n;
        @(posedge PCLK); #1;
        rq.req_valid = 1'b1; rq.req_data = d; rq.req_errmask = m;
        for (n = 0; n < 100 && !rq.req_ready; n++) begin @(posedge PCLK); #1; end
        ok = rq.req_ready;
        if (!ok) begin check("accept_timeout", 0, 1); rq.req_valid = 1'b0; return; end
        acc_cyc = cyc + 1;
        @(posedge PCLK); #1;
        rq.req_valid = 1'b0; rq.req_data = 4'($urandom); rq.req_errmask = 7'($urandom);
        check("req_ready_busy", rq.req_ready, 0);
    endtask

    task automatic issue(input logic [3:0] d, input logic [6:0] m, input int w0, input int w1,
                         input int w2, input int w3, input int mode, input bit chk_lat);
        exp_t e;
        int t, n;
        bit ok;
        logic [4:0] dv;
        e.cw = ham_enc(d);
        dv = ham_dec(e.cw ^ m);
        cfg_w = '{w0, w1, w2, w3}; cfg_mode = mode;
        dec_rds = 0; enc_w_seen = 32'hDEADBEEF; dec_w_seen = 32'hDEADBEEF;
        e.enc_w = {28'h0, d};
        e.dec_w = {25'h0, e.cw ^ m};
        prev_cw = e.cw;
        t = 4 + w0 + w1;
        if (mode == 0) begin
            t += 4 + w2 + w3;
            prev_data = dv[3:0]; prev_corr = dv[4];
            e.mism = dv[3:0] != d; e.st = 2'b00; e.rds = 1;
        end else begin
            t += (mode == 1) ? 2 + w2 : 1 + TMO;
            e.mism = 1'b0; e.st = (mode == 1) ? 2'b01 : 2'b10; e.rds = 0;
        end
        e.data = prev_data; e.corr = prev_corr;
        e.lat = t + 1; e.chk_lat = chk_lat;
        sb.push_back(e);
        send(d, m, ok);
        if (!ok) begin void'(sb.pop_back()); return; end
        for (n = 0; n < 400 && sb.size() != 0; n++) @(posedge PCLK);
        if (sb.size() != 0) begin check("rsp_timeout", 0, 1); sb.delete(); end
        else begin #1; check("req_ready_after", rq.req_ready, 1); end
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_pctl"}, {ab.PSEL_ENC, ab.PSEL_DEC, ab.PENABLE, ab.PWRITE}, 0);
        check({nm, "_paddr_pwdata"}, {ab.PADDR, ab.PWDATA}, 0);
        check({nm, "_handshake"}, {rq.rsp_valid, rq.req_ready}, 2'b01);
        check({nm, "_rsp"}, {rq.rsp_data, rq.rsp_codeword, rq.rsp_corrected, rq.rsp_mismatch, rq.rsp_status}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, a, b, mode;
        logic [6:0] m;
        PRESET = 1'b1;
        rq.req_valid = 1'b0; rq.req_data = '0; rq.req_errmask = '0;
        cfg_w = '{0, 0, 0, 0}; cfg_mode = 0;
        prev_data = '0; prev_cw = '0; prev_corr = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_state("reset");
        PRESET = 1'b0;

        issue(4'hB, 7'h00, 0, 0, 0, 0, 0, 1);
        issue(4'h5, 7'h04, 0, 0, 0, 0, 0, 1);
        issue(4'h6, 7'h00, 0, 3, 0, 0, 0, 1);
        issue(4'h3, 7'h10, 1, 0, 2, 1, 0, 1);
        issue(4'hA, 7'h00, 0, 0, 0, 0, 1, 1);
        issue(4'h9, 7'h40, 0, 0, 0, 0, 2, 1);
        issue(4'hE, 7'h00, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of the encoder read access
        cfg_w = '{0, 6, 0, 0}; cfg_mode = 0;
        send(4'h7, 7'h01, ok);
        for (n = 0; n < 50 && !(ab.PSEL_ENC && ab.PENABLE && !ab.PWRITE); n++) begin
            @(posedge PCLK); #1;
        end
        check("reached_enc_rd_access", {ab.PSEL_ENC, ab.PENABLE, ab.PWRITE}, 3'b110);
        #2 PRESET = 1'b1;
        #1 check_reset_state("midreset");
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        prev_data = '0; prev_cw = '0; prev_corr = 1'b0;
        @(posedge PCLK); #1;
        check("req_ready_post_reset", rq.req_ready, 1);
        issue(4'h7, 7'h01, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            rr_rand = i[0];
            a = $urandom_range(6);
            b = (a + 1 + $urandom_range(5)) % 7;
            case ($urandom_range(2))
                0: m = 7'h00;
                1: m = 7'(1 << a);
                default: m = 7'(1 << a) | 7'(1 << b);
            endcase
            n = $urandom_range(19);
            mode = (n == 0) ? 2 : (n < 3) ? 1 : 0;
            issue(4'($urandom), m, $urandom_range(2), $urandom_range(2), $urandom_range(2),
                  $urandom_range(2), mode, !rr_rand);
        end
        rr_rand = 0;
        repeat (5) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
